// File: rtl/axi_fpuadd_lite_slave_pkg.sv
// Shared AXI4-Lite constants and the byte-merge helper used by the FPU-add register bank.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         ADDR_LSB      = 2;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old;
    for (int k = 0; k < 4; k++) begin
      if (wstrb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_fpuadd_lite_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the FPU-add register bank (slave).
interface axi_fpuadd_lite_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_fpuadd_lite_slave.sv
// AXI4-Lite register bank for the FPU adder: independent AW/W capture, byte strobes,
// one write-pulse per committed register, single outstanding read.
module axi_fpuadd_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  axi_fpuadd_lite_slave_if.slave s_axi,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic [NUM_REGS-1:0]    reg_wr_pulse
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                          aw_held, w_held, bvalid_q, rvalid_q;
  logic [IDX_W-1:0]              aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, rdata_q;
  logic [STRB_W-1:0]             w_strb_q;

  logic                          awready_c, wready_c, arready_c;
  logic                          aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]              wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;

  // Readies depend on state only, so no VALID->READY combinational loop exists
  assign awready_c = !reset && !aw_held && !bvalid_q;
  assign wready_c  = !reset && !w_held  && !bvalid_q;
  assign arready_c = !reset && !rvalid_q;

  assign aw_hs = s_axi.awvalid && awready_c;
  assign w_hs  = s_axi.wvalid  && wready_c;
  assign ar_hs = s_axi.arvalid && arready_c;

  // A held value takes priority; otherwise use what is being handshaken this edge
  assign wr_idx  = aw_held ? aw_idx_q : s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_held  ? w_data_q : s_axi.wdata;
  assign wr_strb = w_held  ? w_strb_q : s_axi.wstrb;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign rd_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      bvalid_q     <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
      if (commit) begin
        regs[wr_idx]         <= apply_wstrb(regs[wr_idx], wr_data, wr_strb);
        reg_wr_pulse[wr_idx] <= 1'b1;
        bvalid_q             <= 1'b1;
        aw_held              <= 1'b0;
        w_held               <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
      end
    end
  end

  // Read path samples the pre-commit register value when both hit the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[rd_idx];
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.arready = arready_c;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = AXI_RESP_OKAY;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = AXI_RESP_OKAY;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[32*g +: 32] = regs[g];
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_fpuadd_lite_slave.sv
// Directed bench for the FPU-add AXI4-Lite register bank with hand-computed expectations.
module tb_axi_fpuadd_lite_slave;

  logic          clock;
  logic          reset;
  logic [127:0]  reg_q;
  logic [3:0]    reg_wr_pulse;
  int            checks;
  int            errors;
  logic [31:0]   rd;
  logic [1:0]    resp;
  logic [3:0]    pulse;

  axi_fpuadd_lite_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  axi_fpuadd_lite_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_REGS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_axi(bus),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic timeout(input string tag);
    errors++;
    $error("FAIL %s timeout", tag);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [3:0] pulse_o, output logic [1:0] bresp_o);
    bit aw_ok, w_ok, done;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    pulse_o = 'x; bresp_o = 'x;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      aw_ok = bus.awvalid && bus.awready;
      w_ok  = bus.wvalid && bus.wready;
      step();
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok)  bus.wvalid  = 1'b0;
      done = !bus.awvalid && !bus.wvalid;
    end
    if (!done) timeout("write_handshake");
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.bvalid) done = 1'b1;
      else step();
    end
    if (!done) timeout("write_bvalid");
    pulse_o = reg_wr_pulse; bresp_o = bus.bresp;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = !bus.bvalid;
    end
    if (!done) timeout("write_bclear");
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data_o, output logic [1:0] rresp_o);
    bit ar_ok, done;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    data_o = 'x; rresp_o = 'x;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      ar_ok = bus.arready;
      step();
      if (ar_ok) begin bus.arvalid = 1'b0; done = 1'b1; end
    end
    if (!done) timeout("read_handshake");
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.rvalid) done = 1'b1;
      else step();
    end
    if (!done) timeout("read_rvalid");
    data_o = bus.rdata; rresp_o = bus.rresp;
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) step();

    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_reg_q", reg_q, 128'h0);
    check("rst_pulse", reg_wr_pulse, 4'h0);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    reset = 1'b0;
    step();
    check("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Sequential write / read-back
    axi_write(4'h0, 32'h1, 4'hF, pulse, resp);
    check("seq_pulse0", pulse, 4'b0001);
    check("seq_bresp", resp, 2'b00);
    axi_write(4'h4, 32'h2, 4'hF, pulse, resp);
    check("seq_pulse1", pulse, 4'b0010);
    axi_write(4'h8, 32'h3, 4'hF, pulse, resp);
    check("seq_pulse2", pulse, 4'b0100);
    axi_write(4'hC, 32'h4, 4'hF, pulse, resp);
    check("seq_pulse3", pulse, 4'b1000);
    check("seq_pulse_clear", reg_wr_pulse, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd, resp);
      check("seq_rdata", rd, 32'(i + 1));
      check("seq_rresp", resp, 2'b00);
    end
    check("seq_reg_q", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});

    // Byte strobes, including a zero-strobe write that still pulses
    axi_write(4'h4, 32'h11223344, 4'hF, pulse, resp);
    axi_write(4'h4, 32'hAABBCCDD, 4'h2, pulse, resp);
    axi_read(4'h4, rd, resp);
    check("strb_rdata", rd, 32'h1122CC44);
    axi_write(4'h5, 32'hFFFFFFFF, 4'h0, pulse, resp);
    check("strb0_pulse", pulse, 4'b0010);
    check("strb0_value", reg_q[63:32], 32'h1122CC44);

    // Split channels: address first, data five cycles later
    bus.awaddr = 4'hC; bus.awvalid = 1'b1; bus.bready = 1'b0;
    step();
    bus.awvalid = 1'b0;
    check("split_awready_low", bus.awready, 1'b0);
    check("split_wready_high", bus.wready, 1'b1);
    repeat (4) step();
    check("split_no_bvalid", bus.bvalid, 1'b0);
    check("split_reg_unchanged", reg_q[127:96], 32'h4);
    bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    check("split_bvalid", bus.bvalid, 1'b1);
    check("split_reg", reg_q[127:96], 32'h77);
    check("split_pulse", reg_wr_pulse, 4'b1000);
    bus.bready = 1'b1;
    step();
    check("split_bclear", bus.bvalid, 1'b0);

    // Write backpressure with a second write pending
    bus.bready = 1'b0;
    bus.awaddr = 4'h0; bus.wdata = 32'hA5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    step();
    bus.awaddr = 4'h4; bus.wdata = 32'h5A;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid", bus.bvalid, 1'b1);
      check("bp_readies", {bus.awready, bus.wready}, 2'b00);
      step();
    end
    check("bp_reg1_held", reg_q[63:32], 32'h1122CC44);
    check("bp_reg0", reg_q[31:0], 32'hA5);
    bus.bready = 1'b1;
    step();
    check("bp_bclear", bus.bvalid, 1'b0);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("bp_second_commit", reg_q[63:32], 32'h5A);
    step();
    check("bp_second_bclear", bus.bvalid, 1'b0);

    // Read backpressure; a concurrent write must not disturb held RDATA
    bus.rready = 1'b0; bus.araddr = 4'h4; bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    axi_write(4'h4, 32'h33, 4'hF, pulse, resp);
    for (int i = 0; i < 10; i++) begin
      check("rbp_hold", {bus.rvalid, bus.arready, bus.rdata}, {1'b1, 1'b0, 32'h5A});
      step();
    end
    bus.rready = 1'b1;
    step();
    check("rbp_rclear", bus.rvalid, 1'b0);

    // Same-edge read and write to one register
    axi_write(4'h8, 32'h5, 4'hF, pulse, resp);
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 4'h8; bus.wdata = 32'h9; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 4'h8; bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("same_edge_rdata_old", bus.rdata, 32'h5);
    check("same_edge_reg_new", reg_q[95:64], 32'h9);
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    axi_read(4'h8, rd, resp);
    check("same_edge_reread", rd, 32'h9);

    // Reset while both responses are pending
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 4'h0; bus.wdata = 32'hDEAD; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 4'h4; bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("pre_rst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
    reset = 1'b1;
    step();
    check("mid_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check("mid_rst_reg_q", reg_q, 128'h0);
    check("mid_rst_rdata", bus.rdata, 32'h0);
    check("mid_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    reset = 1'b0;
    step();
    check("mid_rst_readies_back", {bus.awready, bus.wready, bus.arready}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd, resp);
      check("mid_rst_read_zero", rd, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_fpuadd_lite_slave.md
Name: axi_fpuadd_lite_slave

Overview:
AXI4-Lite responder (slave) holding the FPU-adder's memory-mapped register bank. It sits behind the AXI4-Lite master/interconnect in the block design. It accepts single-beat writes and reads from the bus master and exposes the register contents and write pulses to the FPU-add datapath. All registers are read/write, so a bus master can write a value and read the same value back.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; 2^ADDR_WIDTH/4 registers
NUM_REGS, 4, register count; must equal 2^(C_S_AXI_ADDR_WIDTH-2)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00 (OKAY)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_q  out  NUM_REGS*32  flattened register contents; reg i is at bits [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register written

Behaviour:
- Reset (reset=1 at an edge): all registers 0, BVALID=0, RVALID=0, RDATA=0, reg_wr_pulse=0, internal held-address/held-data flags cleared. AWREADY, WREADY and ARREADY are forced 0 while reset=1. An in-flight transaction is dropped without a response.
- Ready signals are derived only from internal state, with no combinational path from any VALID input:
  - AWREADY = !aw_held && !BVALID
  - WREADY = !w_held && !BVALID
  - ARREADY = !RVALID
- Write channel, address and data captured independently:
  - AW handshake latches AWADDR and sets aw_held.
  - W handshake latches WDATA/WSTRB and sets w_held.
  - Either channel may arrive first, or both in the same cycle.
- Write commit happens at the first edge where both address and data are available (held, or being handshaken this edge):
  - Register index = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - Byte k of the register updated iff WSTRB[k]=1.
  - BVALID rises on the same edge; aw_held/w_held cleared.
  - reg_wr_pulse[idx] is high for exactly the next cycle, even when WSTRB=0.
- Minimum write latency: AW+W handshake at edge N gives BVALID=1 after edge N.
- BVALID holds until an edge with BREADY=1, then falls. No new AW/W is accepted while BVALID=1. Throughput is one write per two cycles when BREADY is held high.
- Read channel:
  - AR handshake at edge N: RDATA <= reg[idx], RVALID=1 after edge N.
  - RVALID and RDATA are held stable until an edge with RREADY=1.
  - ARREADY=0 while RVALID=1.
- Read and write handled independently. A read and a write commit to the same register on the same edge: RDATA returns the old value.
- BRESP/RRESP constant OKAY; no address is out of range (decode covers the full space).
- reg_q reflects the registers with zero delay from the register flops.

Decomposition:
- Package axi_lite_pkg:
  - localparam AXI_RESP_OKAY=2'b00
  - localparam ADDR_LSB=2
  - function apply_wstrb(old, wdata, wstrb) returning the byte-merged word
- Single module; no sub-module. Read and write paths are two always blocks in the same file.

Test Plan:
- Sequential write/read: write 1,2,3,4 to 0x0,0x4,0x8,0xC (WSTRB=0xF), then read each back -> RDATA 0x1,0x2,0x3,0x4, RRESP=0. reg_wr_pulse shows 0001,0010,0100,1000.
- Byte strobe: reg1=0x11223344, write 0xAABBCCDD with WSTRB=0x2 -> read 0x1122CC44.
- Split channels: AWVALID at cycle 0 with WVALID withheld until cycle 5 -> AWREADY drops after the handshake, BVALID rises after the cycle-5 edge, register updated then.
- Backpressure: BREADY=0 for 10 cycles -> BVALID held, AWREADY=WREADY=0 throughout; second write accepted only after BREADY. RREADY=0 for 10 cycles -> RDATA stable, ARREADY=0.
- Same-edge conflict: reg2=0x5, then write 0x9 to 0x8 and read 0x8 on the same edge -> RDATA=0x5; a subsequent read returns 0x9.
- Reset mid-operation: assert reset while BVALID=1 and RVALID=1 -> next cycle BVALID=RVALID=0, all reads afterwards return 0, readies return to 1 one cycle after reset deasserts.
